// File: rtl/shift_pipe_nbit.sv
// Pipelined barrel shifter: SRL / SRA / SLL / ROR, one register stage per shift-amount bit.
// Out-of-range amounts saturate before stage 0; a single global stall freezes the whole pipe.
`timescale 1ns/1ps
module shift_pipe_nbit #(
    parameter int N  = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [AW-1:0] in_amt,
    input  logic [1:0]    in_op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          out_zero
);
    localparam int S = $clog2(N);

    typedef enum logic [1:0] {
        OP_SRL = 2'b00,
        OP_SRA = 2'b01,
        OP_SLL = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    // Handshake: input transfer on in_valid && in_ready, output transfer on
    // out_valid && out_ready. in_ready = adv; when adv is low every stage,
    // bubbles included, holds, which keeps out_data stable under backpressure.
    logic adv;

    logic [N-1:0] data_q [S];
    logic [S-1:0] amt_q  [S];
    op_e          op_q   [S];
    logic [S-1:0] sign_q;
    logic [S-1:0] forced_q;
    logic [S-1:0] valid_q;

    logic [N-1:0] src_data [S];
    logic [S-1:0] src_amt  [S];
    op_e          src_op   [S];
    logic [S-1:0] src_sign;
    logic [S-1:0] src_forced;
    logic [S-1:0] src_valid;
    logic [N-1:0] data_d   [S];

    logic         ovf;
    logic         force_en;
    logic [N-1:0] pre_data;

    function automatic logic [N-1:0] shift_step(input logic [N-1:0] d, input op_e op,
                                                input logic sign, input int unsigned sh);
        logic [2*N-1:0] wide;
        wide = '0;
        case (op)
            OP_SRL:  wide = {{N{1'b0}}, d} >> sh;
            OP_SRA:  wide = {{N{sign}}, d} >> sh;
            OP_SLL:  wide = {{N{1'b0}}, d << sh};
            default: wide = {d, d} >> sh;
        endcase
        return wide[N-1:0];
    endfunction

    // Saturation: shifts by >= N resolve to their final value up front and the
    // stages then pass it through untouched. Rotates just use amount mod N.
    always_comb begin
        ovf      = ({1'b0, in_amt} >= (AW+1)'(N));
        force_en = ovf && (op_e'(in_op) != OP_ROR);
        pre_data = in_data;
        if (force_en) begin
            pre_data = (op_e'(in_op) == OP_SRA) ? {N{in_data[N-1]}} : '0;
        end
    end

    always_comb begin
        src_data   = '{default: '0};
        src_amt    = '{default: '0};
        src_op     = '{default: OP_SRL};
        src_sign   = '0;
        src_forced = '0;
        src_valid  = '0;

        src_data[0]   = pre_data;
        src_amt[0]    = in_amt[S-1:0];
        src_op[0]     = op_e'(in_op);
        src_sign[0]   = in_data[N-1];
        src_forced[0] = force_en;
        src_valid[0]  = in_valid;
        for (int k = 1; k < S; k++) begin
            src_data[k]   = data_q[k-1];
            src_amt[k]    = amt_q[k-1];
            src_op[k]     = op_q[k-1];
            src_sign[k]   = sign_q[k-1];
            src_forced[k] = forced_q[k-1];
            src_valid[k]  = valid_q[k-1];
        end
    end

    always_comb begin
        data_d = '{default: '0};
        for (int k = 0; k < S; k++) begin
            if (src_amt[k][k] && !src_forced[k]) begin
                data_d[k] = shift_step(src_data[k], src_op[k], src_sign[k], 32'(1 << k));
            end else begin
                data_d[k] = src_data[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < S; k++) begin
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                op_q[k]   <= OP_SRL;
            end
            sign_q   <= '0;
            forced_q <= '0;
            valid_q  <= '0;
        end else if (adv) begin
            for (int k = 0; k < S; k++) begin
                data_q[k] <= data_d[k];
                amt_q[k]  <= src_amt[k];
                op_q[k]   <= src_op[k];
            end
            sign_q   <= src_sign;
            forced_q <= src_forced;
            valid_q  <= src_valid;
        end
    end

    // The last stage's control fields have no consumer past the output.
    logic unused_tail;
    assign unused_tail = ^{amt_q[S-1], op_q[S-1], sign_q[S-1], forced_q[S-1]};

    assign out_valid = valid_q[S-1];
    assign out_data  = data_q[S-1];
    assign out_zero  = valid_q[S-1] && (data_q[S-1] == '0);
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

endmodule

// File: tb/tb_shift_pipe_nbit.sv
// Directed bench for shift_pipe_nbit (N=32): per-mode results, saturation, streaming,
// backpressure and mid-flight reset, all against hand-computed expectations.
`timescale 1ns/1ps
module tb_shift_pipe_nbit;
    localparam int N  = 32;
    localparam int AW = 8;

    localparam logic [1:0] SRL = 2'b00;
    localparam logic [1:0] SRA = 2'b01;
    localparam logic [1:0] SLL = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_data = '0;
    logic [AW-1:0] in_amt = '0;
    logic [1:0]    in_op = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [N-1:0]  out_data;
    logic          out_zero;

    int n_tests = 0;
    int n_fail  = 0;
    logic [N-1:0] exp_q[$];

    logic [N-1:0]  v_data [16];
    logic [AW-1:0] v_amt  [16];
    logic [1:0]    v_op   [16];
    logic [N-1:0]  v_exp  [16];

    shift_pipe_nbit #(.N(N), .AW(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [N-1:0] d, input logic [AW-1:0] a,
                           input logic [1:0] op, input logic [N-1:0] e);
        v_data[i] = d;
        v_amt[i]  = a;
        v_op[i]   = op;
        v_exp[i]  = e;
    endtask

    // ---------------- driver: one isolated operand ----------------
    task automatic run_single(input string tag, input logic [N-1:0] d, input logic [AW-1:0] a,
                              input logic [1:0] op, input logic [N-1:0] exp, input logic exp_zero);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        check_eq({tag, " in_ready"}, N'(in_ready), 1);
        in_data  = d;
        in_amt   = a;
        in_op    = op;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = $urandom;
        in_amt   = AW'($urandom_range(0, 255));
        in_op    = 2'($urandom_range(0, 3));
        lat = 1;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
        check_eq({tag, " latency"}, N'(lat), 5);
        check_eq({tag, " data"}, out_data, exp);
        check_eq({tag, " zero"}, N'(out_zero), N'(exp_zero));
        tick();
        check_eq({tag, " no_dup"}, N'(out_valid), 0);
    endtask

    // ---------------- driver + scoreboard: stream with optional stall ----------------
    task automatic run_stream(input string tag, input int n, input int stall_len);
        int sent;
        int got;
        int cyc;
        int stall_cnt;
        int valid_cycles;
        int first;
        int last;
        bit started;
        logic [N-1:0] held;
        sent = 0; got = 0; cyc = 0; stall_cnt = 0;
        valid_cycles = 0; first = -1; last = -1;
        started = 1'b0; held = '0;
        exp_q.delete();
        while (got < n && cyc < 200) begin
            @(posedge clk);
            #1;
            if (!started && out_valid && stall_len > 0) begin
                started   = 1'b1;
                stall_cnt = stall_len;
                held      = out_data;
            end
            out_ready = (stall_cnt == 0);
            #1;
            if (out_valid) begin
                valid_cycles++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (stall_cnt > 0) begin
                check_eq({tag, " stall in_ready"}, N'(in_ready), 0);
                check_eq({tag, " stall hold"}, out_data, held);
                stall_cnt--;
            end else if (out_valid) begin
                check_eq({tag, " q_empty"}, N'(exp_q.size() == 0), 0);
                if (exp_q.size() != 0) check_eq({tag, " data"}, out_data, exp_q.pop_front());
                got++;
            end
            if (sent < n) begin
                in_data  = v_data[sent];
                in_amt   = v_amt[sent];
                in_op    = v_op[sent];
                in_valid = 1'b1;
                if (in_ready) begin
                    exp_q.push_back(v_exp[sent]);
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq({tag, " count"}, N'(got), N'(n));
        check_eq({tag, " leftover"}, N'(exp_q.size()), 0);
        if (stall_len == 0) begin
            check_eq({tag, " valid_cycles"}, N'(valid_cycles), N'(n));
            check_eq({tag, " no_gaps"}, N'(last - first + 1), N'(n));
        end
        tick();
        tick();
        check_eq({tag, " drained"}, N'(out_valid), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w;
        int stale;

        reset_n = 1'b0;
        repeat (3) tick();
        check_eq("reset out_valid", N'(out_valid), 0);
        check_eq("reset out_data", out_data, 0);
        check_eq("reset out_zero", N'(out_zero), 0);
        reset_n = 1'b1;
        #1;
        check_eq("reset in_ready", N'(in_ready), 1);
        tick();

        run_single("srl4", 32'h8000_0010, 8'd4, SRL, 32'h0800_0001, 1'b0);
        run_single("sra4", 32'h8000_0010, 8'd4, SRA, 32'hF800_0001, 1'b0);
        run_single("sll4", 32'h8000_0010, 8'd4, SLL, 32'h0000_0100, 1'b0);
        run_single("ror4", 32'h8000_0010, 8'd4, ROR, 32'h0800_0001, 1'b0);

        run_single("srl32",  32'h8000_0000, 8'd32,  SRL, 32'h0000_0000, 1'b1);
        run_single("srl200", 32'h8000_0000, 8'd200, SRL, 32'h0000_0000, 1'b1);
        run_single("sra32",  32'h8000_0000, 8'd32,  SRA, 32'hFFFF_FFFF, 1'b0);
        run_single("sra200", 32'h8000_0000, 8'd200, SRA, 32'hFFFF_FFFF, 1'b0);
        run_single("sra200p", 32'h7FFF_FFFF, 8'd200, SRA, 32'h0000_0000, 1'b1);
        run_single("sll32",  32'h8000_0000, 8'd32,  SLL, 32'h0000_0000, 1'b1);
        run_single("sll200", 32'h8000_0000, 8'd200, SLL, 32'h0000_0000, 1'b1);
        run_single("ror33",  32'h8000_0000, 8'd33,  ROR, 32'h4000_0000, 1'b0);
        run_single("ror32",  32'h8000_0000, 8'd32,  ROR, 32'h8000_0000, 1'b0);
        run_single("ror64",  32'h1234_5678, 8'd64,  ROR, 32'h1234_5678, 1'b0);

        run_single("srl0", 32'h1234_5678, 8'd0, SRL, 32'h1234_5678, 1'b0);
        run_single("sra0", 32'h9234_5678, 8'd0, SRA, 32'h9234_5678, 1'b0);
        run_single("sll0", 32'h1234_5678, 8'd0, SLL, 32'h1234_5678, 1'b0);
        run_single("ror0", 32'h1234_5678, 8'd0, ROR, 32'h1234_5678, 1'b0);
        run_single("sra31n", 32'h8000_0000, 8'd31, SRA, 32'hFFFF_FFFF, 1'b0);
        run_single("sra31p", 32'h7FFF_FFFF, 8'd31, SRA, 32'h0000_0000, 1'b1);
        run_single("sll31",  32'h0000_0003, 8'd31, SLL, 32'h8000_0000, 1'b0);
        run_single("ror12",  32'h0000_F00F, 8'd12, ROR, 32'h00F0_000F, 1'b0);

        set_vec(0, 32'hFFFF_FFFF, 8'd0, SRL, 32'hFFFF_FFFF);
        set_vec(1, 32'hFFFF_FFFF, 8'd1, SRL, 32'h7FFF_FFFF);
        set_vec(2, 32'hFFFF_FFFF, 8'd2, SRL, 32'h3FFF_FFFF);
        set_vec(3, 32'hFFFF_FFFF, 8'd3, SRL, 32'h1FFF_FFFF);
        set_vec(4, 32'hFFFF_FFFF, 8'd4, SRL, 32'h0FFF_FFFF);
        set_vec(5, 32'hFFFF_FFFF, 8'd5, SRL, 32'h07FF_FFFF);
        set_vec(6, 32'hFFFF_FFFF, 8'd6, SRL, 32'h03FF_FFFF);
        set_vec(7, 32'hFFFF_FFFF, 8'd7, SRL, 32'h01FF_FFFF);
        run_stream("stream", 8, 0);

        set_vec(0, 32'hA5A5_A5A5, 8'd8,  SRL, 32'h00A5_A5A5);
        set_vec(1, 32'hA5A5_A5A5, 8'd8,  SRA, 32'hFFA5_A5A5);
        set_vec(2, 32'hA5A5_A5A5, 8'd8,  SLL, 32'hA5A5_A500);
        set_vec(3, 32'hA5A5_A5A5, 8'd8,  ROR, 32'hA5A5_A5A5);
        set_vec(4, 32'h0000_F00F, 8'd12, ROR, 32'h00F0_000F);
        set_vec(5, 32'h1234_5678, 8'd4,  SLL, 32'h2345_6780);
        set_vec(6, 32'h8000_0001, 8'd40, SRA, 32'hFFFF_FFFF);
        set_vec(7, 32'h8000_0001, 8'd1,  ROR, 32'hC000_0000);
        run_stream("bp", 8, 3);

        // Mid-flight reset: fill the pipe under backpressure, then pull reset.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data  = 32'h0000_0100 << i;
            in_amt   = 8'd1;
            in_op    = SRL;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin
            tick();
            w++;
        end
        check_eq("rst pre out_valid", N'(out_valid), 1);
        reset_n = 1'b0;
        #1;
        check_eq("rst out_valid", N'(out_valid), 0);
        check_eq("rst out_data", out_data, 0);
        check_eq("rst out_zero", N'(out_zero), 0);
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) stale++;
        end
        check_eq("rst stale", N'(stale), 0);
        run_single("post_rst", 32'h0000_00F0, 8'd4, SRL, 32'h0000_000F, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shift_pipe_nbit.md
Name: shift_pipe_nbit

Overview:
- Parametrised, pipelined barrel shifter for the datapath's shift class of ALU operations.
- Supports four modes: logical right, arithmetic right, logical left and rotate right.
- Shift amounts may exceed the data width; each mode has a defined saturation rule.
- Uses one pipeline stage per shift-amount bit, with a valid/ready handshake on input and output so it can sit between the register-read and writeback stages under backpressure.

Parameters:
- N, 32, data width; must be a power of two, 2..128.
- AW, 8, shift-amount width; must satisfy 2**AW >= N.
- S, log2(N), number of pipeline stages; derived, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- in_data  in  N  operand to shift.
- in_amt  in  AW  shift amount, unsigned.
- in_op  in  2  mode: 00 logical right (SRL), 01 arithmetic right (SRA), 10 logical left (SLL), 11 rotate right (ROR).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  N  shifted result.
- out_zero  out  1  high when out_data == 0; qualified by out_valid.

Behaviour:
- Reset:
  - Asynchronous, on reset_n low.
  - All stage valid bits, data, amount, op and sign registers clear to 0.
  - out_valid=0, out_data=0, out_zero=0; in_ready=1 once reset_n is high.
- Transfers: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- Global stall:
  - adv = !out_valid || out_ready.
  - in_ready = adv, combinational.
  - When adv=0, every stage register holds, including bubbles.
  - When adv=1, every stage loads from its predecessor; stage 0 loads the input with valid = in_valid.
- Latency:
  - Exactly S cycles from input transfer to out_valid with no stall; stalls add cycle-for-cycle.
  - Throughput is 1 result per cycle when out_ready stays high.
- Pre-stage decode, combinational before stage 0:
  - ovf = (in_amt >= N).
  - SRL or SLL with ovf: result forced to 0.
  - SRA with ovf: result forced to all copies of in_data[N-1].
  - ROR: effective amount = in_amt mod N (low S bits); ovf is ignored.
  - Otherwise the low S bits of in_amt drive the stages.
- Stage k (k = 0..S-1):
  - If amount bit k is set, shift by 2**k in the selected mode.
  - Vacated bits: 0 for SRL/SLL; the captured sign bit for SRA; wrapped bits for ROR.
  - The sign bit is captured from in_data[N-1] at stage 0 and carried down the pipe.
  - The stage register holds data, the remaining amount bits, op, sign, the forced flag and valid.
- out_zero is computed combinationally from the final stage's data register.
- Corner cases:
  - Amount 0 passes data unchanged in all modes.
  - SRA with amount N-1 gives all sign bits.
  - ROR by N, 2N, ... gives data unchanged.
- Simultaneous input and output transfer in the same cycle is legal and is the steady state.
- in_data, in_amt and in_op may change freely when in_valid=0; they are sampled only on an input transfer.
- out_data must stay stable while out_valid && !out_ready.
- Reset mid-operation: all in-flight operands are discarded and no result emerges after reset release until new inputs arrive.

Test Plan:
- N=32, out_ready=1, one input 0x80000010 with amt=4 in each op:
  - SRL -> 0x08000001.
  - SRA -> 0xF8000001.
  - SLL -> 0x00000100.
  - ROR -> 0x08000001.
  - Each result appears exactly 5 cycles after acceptance, with out_zero=0.
- Overflow amounts, in_data=0x80000000, amt=32 and amt=200:
  - SRL -> 0 with out_zero=1.
  - SRA -> 0xFFFFFFFF.
  - SLL -> 0.
  - ROR with amt=33 -> 0x40000000.
- Back-to-back stream of 8 operands (amt=i, op=SRL, data=0xFFFFFFFF) with out_ready=1:
  - 8 consecutive out_valid cycles.
  - Results 0xFFFFFFFF>>i in order, with no gaps.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1:
  - in_ready=0 for those cycles and out_data holds.
  - After release, no operand is lost or duplicated; scoreboard matches the reference model.
- Assert reset_n low for 1 cycle with 3 operands in flight:
  - out_valid=0 immediately.
  - No stale results after release.
  - The next input's result arrives after 5 cycles.
- Random regression, N=8 and N=64, 10k operands, random out_ready:
  - Every mode and amount in 0..2**AW-1 matches the behavioural model.
